// File: rtl/uart_host_rx.sv
// rtl/uart_host_rx.sv - 8N1 UART receiver assembling 4-byte little-endian packets with inter-byte timeout
// Optional checksum byte enabled by defining UART_HOST_RX_CKSUM_EN (5-byte packets, byte4 = XOR of bytes 0-3).
module uart_host_rx #(
  parameter int BAUD_DIV    = 434,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [31:0] pkt_data,
  output logic        pkt_rdy,
  output logic        frm_err,
  output logic        pkt_err
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef UART_HOST_RX_CKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
  localparam int         NL       = 4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
  localparam int         NL       = 3;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          baud_exp;
  logic          byte_ok;
  logic          byte_bad;
  logic [2:0]    idx;
  logic [NL-1:0][7:0] lanes;
  logic [TW-1:0] to_cnt;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Counter expiry marks the sampling point; stop-bit outcome is visible to the assembler in the same cycle.
  always_comb begin
    baud_exp = (baud_cnt == BW'(1));
    byte_ok  = (state == STOP) && baud_exp && rx_sync;
    byte_bad = (state == STOP) && baud_exp && !rx_sync;
  end

  // Byte FSM: centre-samples start, 8 data bits LSB first, and stop bit; returns to IDLE at mid-stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= START;
            baud_cnt <= BW'(BAUD_DIV / 2);
          end
        end
        START: begin
          if (baud_exp) begin
            if (!rx_sync) begin
              state    <= DATA;
              baud_cnt <= BW'(BAUD_DIV);
              bit_cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        DATA: begin
          if (baud_exp) begin
            shift    <= {rx_sync, shift[7:1]};
            baud_cnt <= BW'(BAUD_DIV);
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        STOP: begin
          if (baud_exp) begin
            state   <= IDLE;
            frm_err <= !rx_sync;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packet assembler: stores bytes into lanes, publishes on the last byte, drops partial packets on error or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      lanes    <= '0;
      to_cnt   <= '0;
      pkt_data <= '0;
      pkt_rdy  <= 1'b0;
`ifdef UART_HOST_RX_CKSUM_EN
      pkt_err  <= 1'b0;
`endif
    end else begin
      pkt_rdy <= 1'b0;
`ifdef UART_HOST_RX_CKSUM_EN
      pkt_err <= 1'b0;
`endif
      if (byte_bad) begin
        idx    <= '0;
        to_cnt <= '0;
      end else if (byte_ok) begin
        to_cnt <= '0;
        if (idx == LAST_IDX) begin
          idx <= '0;
`ifdef UART_HOST_RX_CKSUM_EN
          if (shift == (lanes[0] ^ lanes[1] ^ lanes[2] ^ lanes[3])) begin
            pkt_data <= lanes;
            pkt_rdy  <= 1'b1;
          end else begin
            pkt_err <= 1'b1;
          end
`else
          pkt_data <= {shift, lanes};
          pkt_rdy  <= 1'b1;
`endif
        end else begin
          lanes[idx[1:0]] <= shift;
          idx             <= idx + 3'd1;
        end
      end else if (idx != 3'd0) begin
        if (state == IDLE) begin
          if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            idx    <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

`ifndef UART_HOST_RX_CKSUM_EN
  assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_rx.sv
// tb/tb_uart_host_rx.sv - scoreboard bench for uart_host_rx with directed and random serial traffic
module tb_uart_host_rx;
  localparam int BD = 16;
  localparam int TO = 1000;
`ifdef UART_HOST_RX_CKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] pkt_data;
  logic        pkt_rdy;
  logic        frm_err;
  logic        pkt_err;

  uart_host_rx #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx),
    .pkt_data(pkt_data), .pkt_rdy(pkt_rdy), .frm_err(frm_err), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  // kind: 0 = packet, 1 = framing error, 2 = checksum drop
  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  part[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pkt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a byte list per packet, published when it reaches NB bytes.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [31:0] w;
    logic [7:0]  x;
    if (!good) begin
      exp_q.push_back('{1, 32'h0});
      part.delete();
    end else begin
      part.push_back(b);
      if (part.size() == NB) begin
        w = {part[3], part[2], part[1], part[0]};
        x = part[0] ^ part[1] ^ part[2] ^ part[3];
        if (NB == 5 && part[NB-1] != x) exp_q.push_back('{2, 32'h0});
        else exp_q.push_back('{0, w});
        part.delete();
      end
    end
  endtask

  task automatic wait_bit();
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    model_byte(b, good);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bit();
    end
    rx = good;
    wait_bit();
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    if (n > TO) part.delete();
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
      idle(2);
    end
    if (NB == 5) begin
      send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24], 1'b1);
      idle(2);
    end
  endtask

  task automatic glitch();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic reset_mid(input logic [7:0] b);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_bit();
    end
    rst_n = 1'b0;
    rx = 1'b1;
    part.delete();
    repeat (3) @(negedge clk);
    check("rst_pkt_data", pkt_data, 32'h0);
    check("rst_pkt_rdy", {31'h0, pkt_rdy}, 32'h0);
    check("rst_frm_err", {31'h0, frm_err}, 32'h0);
    check("rst_pkt_err", {31'h0, pkt_err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every strobe and tracks the held packet value.
  always @(negedge clk) begin
    ev_t ev;
    if (!rst_n) begin
      cur_pkt = '0;
    end else begin
      if (pkt_rdy || frm_err || pkt_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual rdy/frm/perr=%b%b%b required none", pkt_rdy, frm_err, pkt_err);
        end else begin
          ev = exp_q.pop_front();
          check("strobe_kind", {29'h0, pkt_rdy, frm_err, pkt_err},
                (ev.kind == 0) ? 32'h4 : (ev.kind == 1) ? 32'h2 : 32'h1);
          if (ev.kind == 0) cur_pkt = ev.data;
        end
      end
      check("pkt_data", pkt_data, cur_pkt);
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_pkt_data", pkt_data, 32'h0);
    check("reset_pkt_rdy", {31'h0, pkt_rdy}, 32'h0);
    check("reset_frm_err", {31'h0, frm_err}, 32'h0);
    check("reset_pkt_err", {31'h0, pkt_err}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_pkt(32'h44332211);
    glitch();
    send_pkt(32'h00FF5AA5);
    send_byte(8'h55, 1'b0);
    idle(3);
    send_pkt(32'h04030201);
    send_byte(8'hDE, 1'b1);
    idle(2);
    send_byte(8'hAD, 1'b1);
    idle(1200);
    send_pkt(32'h04030201);
    send_byte(8'h10, 1'b1);
    idle(2);
    send_byte(8'h11, 1'b1);
    idle(2);
    reset_mid(8'h12);
    send_pkt(32'h13121110);
`ifdef UART_HOST_RX_CKSUM_EN
    for (int i = 1; i <= 4; i++) begin
      send_byte(i[7:0], 1'b1);
      idle(2);
    end
    send_byte(8'h04, 1'b1);
    idle(2);
    for (int i = 1; i <= 4; i++) begin
      send_byte(i[7:0], 1'b1);
      idle(2);
    end
    send_byte(8'h05, 1'b1);
    idle(2);
`endif

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        glitch();
      end else if (r < 8) begin
        idle(1200);
      end else if (r < 13) begin
        send_byte(8'($urandom), 1'b0);
        idle($urandom_range(2, 40));
      end else if (r < 15) begin
        reset_mid(8'($urandom));
      end else begin
        b = 8'($urandom);
        if (NB == 5 && part.size() == 4 && $urandom_range(0, 1) == 1)
          b = part[0] ^ part[1] ^ part[2] ^ part[3];
        send_byte(b, 1'b1);
        idle($urandom_range(2, 40));
      end
    end

    repeat (100) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
